debug_uart_tx: RTL and testbench

DEBUG_UART_TX -- requirements
Module: debug_uart_tx

---
 rtl/debug_uart_tx.sv | 121 ++++++++++++
 tb/tb_debug_uart_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// Debug UART transmitter: sends a 16-bit debug word as "HHHH\r\n" (8N1, LSB first)
// whenever the word changes, when forced, and once after every reset.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] debug,
    // "force" is a reserved word in SystemVerilog, hence force_send
    input  logic        force_send,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  frames_sent
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [15:0] snapshot;
    logic [15:0] last_sent;
    logic        init_pending;
    logic [7:0]  cur_byte;
    logic        bit_done;
    logic        launch;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            3'd0:    cur_byte = hex(snapshot[15:12]);
            3'd1:    cur_byte = hex(snapshot[11:8]);
            3'd2:    cur_byte = hex(snapshot[7:4]);
            3'd3:    cur_byte = hex(snapshot[3:0]);
            3'd4:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign bit_done = (bit_cnt == 16'(CLKS_PER_BIT - 1));
    assign launch   = (debug != last_sent) || force_send || init_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            snapshot     <= '0;
            last_sent    <= '0;
            init_pending <= 1'b1;
            tx           <= 1'b1;
            busy         <= 1'b0;
            frames_sent  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state        <= START;
                        snapshot     <= debug;
                        last_sent    <= debug;
                        init_pending <= 1'b0;
                        bit_cnt      <= '0;
                        byte_idx     <= '0;
                        tx           <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        // next start bit follows the stop bit with no idle gap
                        if (byte_idx < 3'd5) begin
                            state    <= START;
                            byte_idx <= byte_idx + 3'd1;
                            tx       <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            byte_idx    <= '0;
                            busy        <= 1'b0;
                            frames_sent <= frames_sent + 8'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: directed stimulus pushes expected frame bytes into a queue,
// a UART receiver process decodes tx and compares each received byte against it.
`timescale 1ns/1ps
module tb_debug_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] debug = 16'h0000;
    logic        force_send = 1'b0;
    logic        tx;
    logic        busy;
    logic [7:0]  frames_sent;

    int tests  = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    debug_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .debug(debug), .force_send(force_send),
        .tx(tx), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_frame(input logic [15:0] v);
        exp_q.push_back(hx(v[15:12]));
        exp_q.push_back(hx(v[11:8]));
        exp_q.push_back(hx(v[7:4]));
        exp_q.push_back(hx(v[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_rise(input string name);
        int n = 0;
        while (!busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!busy) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_idle(output int n);
        n = 0;
        while (!busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // UART receiver / scoreboard monitor
    initial begin
        int         pos;
        logic       active;
        logic [7:0] rx;
        active = 1'b0;
        pos    = 0;
        rx     = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx == 1'b0) begin
                    active = 1'b1;
                    pos    = 0;
                end
            end else begin
                pos++;
                for (int i = 0; i < 8; i++)
                    if (pos == CPB/2 + CPB*(i+1)) rx[i] = tx;
                if (pos == CPB/2 + 9*CPB) begin
                    active = 1'b0;
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) check("unexpected_byte", {24'd0, rx}, 32'hFFFF_FFFF);
                    else check("rx_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frames", {24'd0, frames_sent}, 32'd0);

        // init frame after reset release
        push_frame(16'h0000);
        @(posedge clk); #1 rst = 1'b1;
        wait_rise("init");
        count_busy(n);
        check("init_busy_len", n, 32'd240);
        check("init_frames", {24'd0, frames_sent}, 32'd1);
        repeat (30) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_tx", {31'd0, tx}, 32'd1);

        // debug change launches with one-cycle latency
        @(posedge clk); #1 debug = 16'h1A2F;
        push_frame(16'h1A2F);
        @(negedge clk);
        check("pre_launch_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("launch_tx", {31'd0, tx}, 32'd0);
        check("launch_busy", {31'd0, busy}, 32'd1);
        count_busy(n);
        check("chg_busy_len", n, 32'd240);
        check("chg_frames", {24'd0, frames_sent}, 32'd2);

        // debug changes mid-frame do not disturb it; one follow-up frame
        @(posedge clk); #1 force_send = 1'b1;
        push_frame(16'h1A2F);
        @(posedge clk); #1 force_send = 1'b0;
        wait_rise("midchg");
        repeat (49) @(posedge clk);
        #1 debug = 16'hBEEF;
        repeat (50) @(posedge clk);
        #1 debug = 16'hFFFF;
        push_frame(16'hFFFF);
        @(negedge clk);
        count_busy(n);
        count_idle(n);
        check("followup_gap", n, 32'd1);
        count_busy(n);
        check("followup_len", n, 32'd240);
        repeat (30) @(negedge clk);
        check("no_extra_frame", {31'd0, busy}, 32'd0);
        check("midchg_frames", {24'd0, frames_sent}, 32'd4);

        // force held with simultaneous debug change: three frames, 1 idle between
        @(posedge clk); #1 debug = 16'h00C3; force_send = 1'b1;
        push_frame(16'h00C3); push_frame(16'h00C3); push_frame(16'h00C3);
        wait_rise("force");
        count_busy(n);
        check("force_len1", n, 32'd240);
        count_idle(n);
        check("force_gap1", n, 32'd1);
        count_busy(n);
        check("force_len2", n, 32'd240);
        count_idle(n);
        check("force_gap2", n, 32'd1);
        force_send = 1'b0;
        count_busy(n);
        check("force_len3", n, 32'd240);
        repeat (30) @(negedge clk);
        check("force_stop", {31'd0, busy}, 32'd0);
        check("force_frames", {24'd0, frames_sent}, 32'd7);

        // reset mid-frame aborts immediately, then fresh frame
        @(posedge clk); #1 debug = 16'h5A5A;
        push_frame(16'h5A5A);
        wait_rise("abort");
        repeat (120) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_frames", {24'd0, frames_sent}, 32'd0);
        check("abort_bytes_left", exp_q.size(), 32'd3);
        exp_q.delete();
        push_frame(16'h5A5A);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_rise("post_abort");
        count_busy(n);
        check("post_abort_len", n, 32'd240);
        check("post_abort_frames", {24'd0, frames_sent}, 32'd1);

        // 256 frames since reset: counter wraps to 0
        @(posedge clk); #1 rst = 1'b0; debug = 16'h0123; force_send = 1'b1;
        for (int i = 0; i < 256; i++) push_frame(16'h0123);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_rise("wrap");
            if (i == 255) begin
                check("pre_wrap_frames", {24'd0, frames_sent}, 32'd255);
                force_send = 1'b0;
            end
            count_busy(n);
            check("wrap_len", n, 32'd240);
        end
        check("wrap_frames", {24'd0, frames_sent}, 32'd0);
        repeat (50) @(negedge clk);
        check("final_busy", {31'd0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
